// File: rtl/barrel_pkg.sv
// Shared types and defaults for the Kong-side barrel launcher and its interface.
package barrel_pkg;

  typedef enum logic [1:0] {
    ST_READY     = 2'd0,
    ST_COOLDOWN  = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  localparam int N_BARRELS_DEF  = 4;
  localparam int LIVES_INIT_DEF = 3;
  localparam int COOLDOWN_DEF   = 20000000;
  localparam int TIMEOUT_DEF    = 2**26;

  // Bits needed to hold every value in 0..max_val (at least one).
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/barrel_dispatcher_if.sv
// Throw/launch/done/hit bundle between the Kong launcher (master) and the barrel pool side (slave).
interface barrel_dispatcher_if #(
  parameter int N_BARRELS = barrel_pkg::N_BARRELS_DEF
);
  logic                 throw_btn;
  logic                 restart;
  logic [N_BARRELS-1:0] barrel_en;
  logic [N_BARRELS-1:0] barrel_done;
  logic [N_BARRELS-1:0] barrel_hit;
  logic                 throw_ack;
  logic                 throw_nack;
  logic                 hit_evt;
  logic                 timeout_evt;
  logic [1:0]           lives;
  logic                 game_over;

  modport master (
    input  throw_btn, restart, barrel_done, barrel_hit,
    output barrel_en, throw_ack, throw_nack, hit_evt, timeout_evt, lives, game_over
  );

  modport slave (
    output throw_btn, restart, barrel_done, barrel_hit,
    input  barrel_en, throw_ack, throw_nack, hit_evt, timeout_evt, lives, game_over
  );
endinterface

// File: rtl/slot_watchdog.sv
// Per-slot busy-time counter; flags a slot that stayed busy TIMEOUT_CYCLES without a done.
module slot_watchdog
  import barrel_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  input  logic done,
  output logic timeout
);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !busy) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // A done arriving on the expiry cycle wins, so no force-free is reported.
  assign timeout = busy && !done && (cnt == CNT_MAX);

endmodule

// File: rtl/barrel_dispatcher.sv
// Kong throw button to lowest-free-slot barrel launches, with completion, lives and watchdog tracking.
module barrel_dispatcher
  import barrel_pkg::*;
#(
  parameter int N_BARRELS       = N_BARRELS_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_DEF,
  parameter int TIMEOUT_CYCLES  = TIMEOUT_DEF,
  parameter int LIVES_INIT      = LIVES_INIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  barrel_dispatcher_if.master   bus
);
  localparam int CD_W = cnt_width(COOLDOWN_CYCLES - 1);
  localparam logic [CD_W-1:0] CD_LOAD   = CD_W'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]      LIVES_RST = 2'(LIVES_INIT);

  logic throw_p0, throw_p1, throw_p2, throw_req_p3;

  state_t               state, state_n;
  logic [N_BARRELS-1:0] busy, busy_n;
  logic [N_BARRELS-1:0] free, launch_oh;
  logic [N_BARRELS-1:0] done_q, hit_q, wd_to;
  logic [CD_W-1:0]      cd_cnt, cd_n;
  logic [1:0]           lives, lives_n;
  logic                 ack, nack, hit_any, to_any;

  // Stages p0/p1: synchronizer; p2: previous level; p3: registered rising edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      throw_p0     <= 1'b0;
      throw_p1     <= 1'b0;
      throw_p2     <= 1'b0;
      throw_req_p3 <= 1'b0;
    end else begin
      throw_p0     <= bus.throw_btn;
      throw_p1     <= throw_p0;
      throw_p2     <= throw_p1;
      throw_req_p3 <= throw_p1 & ~throw_p2;
    end
  end

  assign free      = ~busy;
  assign launch_oh = free & (~free + N_BARRELS'(1));
  assign done_q    = bus.barrel_done & busy;
  assign hit_q     = done_q & bus.barrel_hit;

  for (genvar i = 0; i < N_BARRELS; i++) begin : g_wd
    slot_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wd (
      .clk     (clk),
      .rst     (rst),
      .busy    (busy[i]),
      .done    (bus.barrel_done[i]),
      .timeout (wd_to[i])
    );
  end

  always_comb begin
    state_n = state;
    busy_n  = busy & ~done_q & ~wd_to;
    cd_n    = cd_cnt;
    lives_n = lives;
    ack     = 1'b0;
    nack    = 1'b0;
    hit_any = 1'b0;
    to_any  = 1'b0;

    case (state)
      ST_READY: begin
        if (throw_req_p3) begin
          if (|free) begin
            busy_n  = busy_n | launch_oh;
            ack     = 1'b1;
            cd_n    = CD_LOAD;
            state_n = ST_COOLDOWN;
          end else begin
            nack = 1'b1;
          end
        end
      end
      ST_COOLDOWN: begin
        nack = throw_req_p3;
        if (cd_cnt == '0) begin
          state_n = ST_READY;
        end else begin
          cd_n = cd_cnt - CD_W'(1);
        end
      end
      ST_GAME_OVER: begin
        busy_n = '0;
        if (bus.restart) begin
          lives_n = LIVES_RST;
          cd_n    = '0;
          state_n = ST_READY;
        end
      end
      default: begin
        state_n = ST_READY;
      end
    endcase

    // Several hits in one cycle cost a single life.
    if (state != ST_GAME_OVER) begin
      hit_any = |hit_q;
      to_any  = |wd_to;
      if (hit_any && lives != 2'd0) begin
        lives_n = lives - 2'd1;
        if (lives == 2'd1) begin
          state_n = ST_GAME_OVER;
          busy_n  = '0;
          cd_n    = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_READY;
      busy   <= '0;
      cd_cnt <= '0;
      lives  <= LIVES_RST;
    end else begin
      state  <= state_n;
      busy   <= busy_n;
      cd_cnt <= cd_n;
      lives  <= lives_n;
    end
  end

  assign bus.barrel_en   = busy;
  assign bus.lives       = lives;
  assign bus.game_over   = (state == ST_GAME_OVER);
  assign bus.throw_ack   = ack     & ~rst;
  assign bus.throw_nack  = nack    & ~rst;
  assign bus.hit_evt     = hit_any & ~rst;
  assign bus.timeout_evt = to_any  & ~rst;

endmodule

// File: tb/tb_barrel_dispatcher.sv
// Directed bench for barrel_dispatcher with short cooldown (10) and watchdog (100) settings.
module tb_barrel_dispatcher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  barrel_dispatcher_if #(.N_BARRELS(4)) bus ();

  barrel_dispatcher #(
    .N_BARRELS       (4),
    .COOLDOWN_CYCLES (10),
    .TIMEOUT_CYCLES  (100),
    .LIVES_INIT      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.throw_btn   = 1'b0;
    bus.restart     = 1'b0;
    bus.barrel_done = 4'b0;
    bus.barrel_hit  = 4'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Samples ack/nack on the cycle the synchronized edge reaches the FSM.
  task automatic press(output logic ack, output logic nack);
    bus.throw_btn = 1'b1;
    repeat (3) tick();
    ack  = bus.throw_ack;
    nack = bus.throw_nack;
    bus.throw_btn = 1'b0;
    tick();
    tick();
  endtask

  task automatic launch(input string tag);
    logic a, n;
    press(a, n);
    check_eq(tag, {30'd0, a, n}, 32'b10);
    repeat (8) tick();
  endtask

  task automatic pulse_done(input logic [3:0] d, input logic [3:0] h,
                            output logic hit_s, output logic to_s);
    bus.barrel_done = d;
    bus.barrel_hit  = h;
    #1;
    hit_s = bus.hit_evt;
    to_s  = bus.timeout_evt;
    tick();
    bus.barrel_done = 4'b0;
    bus.barrel_hit  = 4'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic a, n, h, t;
    int waited;

    // Reset state and first-throw latency.
    do_reset();
    check_eq("rst_en", bus.barrel_en, 4'b0000);
    check_eq("rst_lives", bus.lives, 2'd3);
    check_eq("rst_go", bus.game_over, 1'b0);
    check_eq("rst_pulses", {bus.throw_ack, bus.throw_nack, bus.hit_evt, bus.timeout_evt}, 4'b0);
    bus.throw_btn = 1'b1;
    tick();
    check_eq("ack_c1", bus.throw_ack, 1'b0);
    tick();
    check_eq("ack_c2", bus.throw_ack, 1'b0);
    tick();
    check_eq("ack_c3", bus.throw_ack, 1'b1);
    check_eq("en_c3", bus.barrel_en, 4'b0000);
    tick();
    check_eq("en_c4", bus.barrel_en, 4'b0001);
    check_eq("ack_c4", bus.throw_ack, 1'b0);
    bus.throw_btn = 1'b0;
    tick();
    tick();
    press(a, n);
    check_eq("cooldown_nack", {30'd0, a, n}, 32'b01);
    check_eq("cooldown_en", bus.barrel_en, 4'b0001);

    // Fill all slots, reject when full, refill after a done.
    do_reset();
    launch("fill0");
    launch("fill1");
    launch("fill2");
    launch("fill3");
    check_eq("full_en", bus.barrel_en, 4'b1111);
    press(a, n);
    check_eq("full_nack", {30'd0, a, n}, 32'b01);
    pulse_done(4'b0100, 4'b0000, h, t);
    check_eq("done2_hit", h, 1'b0);
    check_eq("done2_en", bus.barrel_en, 4'b1011);
    press(a, n);
    check_eq("refill_ack", {30'd0, a, n}, 32'b10);
    check_eq("refill_en", bus.barrel_en, 4'b1111);

    // Two hits in one cycle cost one life.
    pulse_done(4'b0011, 4'b0011, h, t);
    check_eq("dbl_hit_evt", h, 1'b1);
    check_eq("dbl_lives", bus.lives, 2'd2);
    check_eq("dbl_en", bus.barrel_en, 4'b1100);

    // Three hits end the game; restart recovers.
    do_reset();
    launch("go0");
    launch("go1");
    launch("go2");
    launch("go3");
    pulse_done(4'b0001, 4'b0001, h, t);
    check_eq("go_hit1", {31'd0, h}, 1'b1);
    check_eq("go_lives1", bus.lives, 2'd2);
    pulse_done(4'b0010, 4'b0010, h, t);
    check_eq("go_lives2", bus.lives, 2'd1);
    pulse_done(4'b0100, 4'b0100, h, t);
    check_eq("go_hit3", h, 1'b1);
    check_eq("go_lives0", bus.lives, 2'd0);
    check_eq("go_flag", bus.game_over, 1'b1);
    check_eq("go_en", bus.barrel_en, 4'b0000);
    press(a, n);
    check_eq("go_ignore", {30'd0, a, n}, 32'b00);
    check_eq("go_ignore_en", bus.barrel_en, 4'b0000);
    bus.restart = 1'b1;
    tick();
    bus.restart = 1'b0;
    check_eq("restart_lives", bus.lives, 2'd3);
    check_eq("restart_go", bus.game_over, 1'b0);
    press(a, n);
    check_eq("restart_ack", {30'd0, a, n}, 32'b10);
    check_eq("restart_en", bus.barrel_en, 4'b0001);

    // Watchdog force-free, then done on the expiry cycle suppresses it.
    do_reset();
    press(a, n);
    check_eq("wd_ack", a, 1'b1);
    waited = 0;
    while (!bus.timeout_evt && waited < 150) begin
      tick();
      waited++;
    end
    check_eq("wd_fired", bus.timeout_evt, 1'b1);
    check_eq("wd_latency", waited, 98);
    check_eq("wd_en_before", bus.barrel_en, 4'b0001);
    tick();
    check_eq("wd_en_after", bus.barrel_en, 4'b0000);
    check_eq("wd_pulse_end", bus.timeout_evt, 1'b0);
    press(a, n);
    check_eq("wd2_ack", a, 1'b1);
    repeat (98) tick();
    bus.barrel_done = 4'b0001;
    #1;
    check_eq("wd_done_prio", bus.timeout_evt, 1'b0);
    tick();
    bus.barrel_done = 4'b0000;
    check_eq("wd_done_en", bus.barrel_en, 4'b0000);

    // Reset mid-play, then stray done/hit on a free slot.
    do_reset();
    launch("mr0");
    launch("mr1");
    launch("mr2");
    launch("mr3");
    pulse_done(4'b1000, 4'b1000, h, t);
    check_eq("mr_lives_pre", bus.lives, 2'd2);
    check_eq("mr_en_pre", bus.barrel_en, 4'b0111);
    rst = 1'b1;
    tick();
    check_eq("mr_en", bus.barrel_en, 4'b0000);
    check_eq("mr_lives", bus.lives, 2'd3);
    rst = 1'b0;
    pulse_done(4'b0010, 4'b0010, h, t);
    check_eq("stray_hit", h, 1'b0);
    check_eq("stray_lives", bus.lives, 2'd3);
    check_eq("stray_en", bus.barrel_en, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
